// File: rtl/conv3x3_stream.sv
// Streaming 3x3 valid-region convolution: one result per accepted pixel once the window is full, 1-cycle latency.
// Single output register; s_axis_tready drops while a result is held unaccepted (always ready while dropping).
module conv3x3_stream #(
    parameter  int PIXEL_WIDTH    = 8,
    parameter  int KERNEL_ENTRIES = 10,
    parameter  int WEIGHT_RES     = 8,
    parameter  int MAX_DIM        = 32,
    parameter  int OUT_WIDTH      = 32,
    localparam int DIM_W          = $clog2(MAX_DIM)
) (
    input  logic                                 clk_i,
    input  logic                                 resetn_i,
    input  logic [KERNEL_ENTRIES*WEIGHT_RES-1:0] kernel_i,
    input  logic [DIM_W-1:0]                     image_dimension_i,
    input  logic [PIXEL_WIDTH-1:0]               s_axis_tdata,
    input  logic                                 s_axis_tvalid,
    input  logic                                 s_axis_tlast,
    output logic                                 s_axis_tready,
    output logic [OUT_WIDTH-1:0]                 m_axis_tdata,
    output logic                                 m_axis_tvalid,
    input  logic                                 m_axis_tready,
    output logic                                 m_axis_tlast,
    output logic                                 busy_o,
    output logic                                 err_o
);
    localparam int PROD_W = WEIGHT_RES + PIXEL_WIDTH + 1;
    localparam int SUM_W  = PROD_W + 4;

    typedef enum logic [1:0] {IDLE, RUN, DROP} state_t;

    state_t                               r_state;
    logic [KERNEL_ENTRIES*WEIGHT_RES-1:0] r_kernel;
    logic [DIM_W-1:0]                     r_n;
    logic [DIM_W-1:0]                     r_row;
    logic [DIM_W-1:0]                     r_col;
    logic [PIXEL_WIDTH-1:0]               r_lb0 [MAX_DIM];
    logic [PIXEL_WIDTH-1:0]               r_lb1 [MAX_DIM];
    logic [PIXEL_WIDTH-1:0]               r_win [9];
    logic [OUT_WIDTH-1:0]                 r_m_tdata;
    logic                                 r_m_tvalid;
    logic                                 r_m_tlast;
    logic                                 r_err;

    logic                                 w_s_tready;
    logic                                 w_acc;
    logic                                 w_proc;
    logic [DIM_W-1:0]                     w_n;
    logic                                 w_last_col;
    logic                                 w_frame_end;
    logic                                 w_out;
    logic [PIXEL_WIDTH-1:0]               w_win_next [9];
    logic signed [PROD_W-1:0]             w_prod;
    logic signed [SUM_W-1:0]              w_sum;

    assign w_s_tready  = (r_state == DROP) | !r_m_tvalid | m_axis_tready;
    assign w_acc       = s_axis_tvalid & w_s_tready;
    // In IDLE the first pixel is processed with the dimension being latched on the same edge.
    assign w_n         = (r_state == IDLE) ? image_dimension_i : r_n;
    assign w_proc      = (r_state == RUN) | ((r_state == IDLE) & (image_dimension_i >= DIM_W'(3)));
    assign w_last_col  = (r_col == w_n - DIM_W'(1));
    assign w_frame_end = w_last_col & (r_row == w_n - DIM_W'(1));
    assign w_out       = w_proc & (r_row >= DIM_W'(2)) & (r_col >= DIM_W'(2));

    always_comb begin
        w_win_next[0] = r_win[1];
        w_win_next[1] = r_win[2];
        w_win_next[2] = r_lb1[r_col];
        w_win_next[3] = r_win[4];
        w_win_next[4] = r_win[5];
        w_win_next[5] = r_lb0[r_col];
        w_win_next[6] = r_win[7];
        w_win_next[7] = r_win[8];
        w_win_next[8] = s_axis_tdata;
    end

    always_comb begin
        w_sum  = SUM_W'($signed(r_kernel[(KERNEL_ENTRIES-1)*WEIGHT_RES +: WEIGHT_RES]));
        w_prod = '0;
        for (int k = 0; k < 9; k++) begin
            w_prod = PROD_W'($signed(r_kernel[k*WEIGHT_RES +: WEIGHT_RES]))
                   * PROD_W'($signed({1'b0, w_win_next[k]}));
            w_sum  = w_sum + SUM_W'(w_prod);
        end
    end

    // Line buffers and window carry no reset; rows >= 2 only ever read current-frame data.
    always_ff @(posedge clk_i) begin
        if (w_acc & w_proc) begin
            r_lb1[r_col] <= r_lb0[r_col];
            r_lb0[r_col] <= s_axis_tdata;
            r_win        <= w_win_next;
        end
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            r_state    <= IDLE;
            r_kernel   <= '0;
            r_n        <= '0;
            r_row      <= '0;
            r_col      <= '0;
            r_m_tdata  <= '0;
            r_m_tvalid <= 1'b0;
            r_m_tlast  <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_err <= w_acc & w_proc & (w_frame_end ^ s_axis_tlast);

            if (w_acc) begin
                case (r_state)
                    IDLE: begin
                        r_kernel <= kernel_i;
                        r_n      <= image_dimension_i;
                        if (!w_proc) r_state <= s_axis_tlast ? IDLE : DROP;
                    end
                    DROP:    if (s_axis_tlast) r_state <= IDLE;
                    default: ;
                endcase
            end

            if (w_acc & w_proc) begin
                if (w_frame_end | s_axis_tlast) begin
                    r_state <= IDLE;
                    r_row   <= '0;
                    r_col   <= '0;
                end else begin
                    r_state <= RUN;
                    if (w_last_col) begin
                        r_col <= '0;
                        r_row <= r_row + DIM_W'(1);
                    end else begin
                        r_col <= r_col + DIM_W'(1);
                    end
                end
            end

            if (w_acc & w_out) begin
                r_m_tdata  <= {{(OUT_WIDTH-SUM_W){w_sum[SUM_W-1]}}, w_sum};
                r_m_tvalid <= 1'b1;
                r_m_tlast  <= w_frame_end;
            end else if (m_axis_tready) begin
                r_m_tvalid <= 1'b0;
                r_m_tlast  <= 1'b0;
            end
        end
    end

    assign s_axis_tready = w_s_tready;
    assign m_axis_tdata  = r_m_tdata;
    assign m_axis_tvalid = r_m_tvalid;
    assign m_axis_tlast  = r_m_tlast;
    assign busy_o        = (r_state != IDLE);
    assign err_o         = r_err;
endmodule

// File: tb/tb_conv3x3_stream.sv
// Bench for conv3x3_stream: randomized frames against a frame-array reference model plus literal scenarios.
module tb_conv3x3_stream;
    logic        clk_i = 1'b0;
    logic        resetn_i = 1'b1;
    logic [79:0] kernel_i = '0;
    logic [4:0]  image_dimension_i = '0;
    logic [7:0]  s_axis_tdata = '0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tlast = 1'b0;
    logic        s_axis_tready;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b1;
    logic        m_axis_tlast;
    logic        busy_o;
    logic        err_o;

    conv3x3_stream dut (
        .clk_i(clk_i), .resetn_i(resetn_i), .kernel_i(kernel_i),
        .image_dimension_i(image_dimension_i),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
        .busy_o(busy_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    int errors = 0;
    int checks = 0;

    // reference model state: mode 0 idle, 1 in frame, 2 dropping
    int          mode = 0;
    int          m_n = 0;
    int          mk [10];
    int          m_idx = 0;
    int          img [32][32];
    int          exp_q [$];
    bit          expl_q [$];
    int          got_q [$];
    bit          gotl_q [$];
    bit          exp_err_pend = 0;
    bit          exp_vld_pend = 0;
    int          exp_vld_dat = 0;
    bit          prev_hold = 0;
    logic [31:0] prev_dat = '0;
    bit          prev_last = 0;
    int          err_seen = 0;
    bit          rdy_rnd = 0;
    bit          rdy_zero = 0;

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic model_pixel(input int p, input bit last);
        int r, c, s;
        if (mode == 0) begin
            m_n = int'(image_dimension_i);
            for (int k = 0; k < 10; k++) mk[k] = int'($signed(kernel_i[k*8 +: 8]));
            m_idx = 0;
            if (m_n < 3) begin
                mode = last ? 0 : 2;
                return;
            end
            mode = 1;
        end else if (mode == 2) begin
            if (last) mode = 0;
            return;
        end
        r = m_idx / m_n;
        c = m_idx % m_n;
        img[r][c] = p;
        if (r >= 2 && c >= 2) begin
            s = mk[9];
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                    s += mk[i*3+j] * img[r-2+i][c-2+j];
            exp_q.push_back(s);
            expl_q.push_back(m_idx == m_n*m_n - 1);
            exp_vld_pend = 1;
            exp_vld_dat  = s;
        end
        if (m_idx == m_n*m_n - 1) begin
            exp_err_pend = !last;
            mode = 0;
        end else if (last) begin
            exp_err_pend = 1;
            mode = 0;
        end else begin
            m_idx++;
        end
    endtask

    always @(negedge clk_i) begin
        if (resetn_i) begin
            chk(err_o == exp_err_pend, "err_o", {31'b0, err_o}, {31'b0, exp_err_pend});
            if (err_o) err_seen++;
            if (exp_vld_pend)
                chk(m_axis_tvalid && m_axis_tdata == exp_vld_dat, "latency", m_axis_tdata, exp_vld_dat);
            if (prev_hold)
                chk(m_axis_tvalid && m_axis_tdata == prev_dat && m_axis_tlast == prev_last,
                    "hold_stable", m_axis_tdata, prev_dat);
            chk(busy_o == (mode != 0), "busy_o", {31'b0, busy_o}, {31'b0, mode != 0});
            chk(s_axis_tready == (mode == 2 || !m_axis_tvalid || m_axis_tready), "s_tready",
                {31'b0, s_axis_tready}, {31'b0, (mode == 2 || !m_axis_tvalid || m_axis_tready)});
            if (m_axis_tvalid && m_axis_tready) begin
                if (exp_q.size() == 0) begin
                    chk(0, "unexpected_output", m_axis_tdata, 0);
                end else begin
                    int e;
                    bit el;
                    e  = exp_q.pop_front();
                    el = expl_q.pop_front();
                    chk(m_axis_tdata == e, "out_data", m_axis_tdata, e);
                    chk(m_axis_tlast == el, "out_last", {31'b0, m_axis_tlast}, {31'b0, el});
                end
                got_q.push_back(int'(m_axis_tdata));
                gotl_q.push_back(m_axis_tlast);
            end
            prev_hold = m_axis_tvalid && !m_axis_tready;
            prev_dat  = m_axis_tdata;
            prev_last = m_axis_tlast;
            exp_err_pend = 0;
            exp_vld_pend = 0;
            if (s_axis_tvalid && s_axis_tready) model_pixel(int'(s_axis_tdata), s_axis_tlast);
        end
    end

    always @(posedge clk_i) begin
        #1;
        m_axis_tready = rdy_zero ? 1'b0 : (rdy_rnd ? 1'($urandom_range(0, 1)) : 1'b1);
    end

    function automatic logic [79:0] kmk(input int wall, input int wctr, input int bias);
        logic [79:0] k;
        for (int i = 0; i < 9; i++) k[i*8 +: 8] = 8'((i == 4) ? wctr : wall);
        k[72 +: 8] = 8'(bias);
        return k;
    endfunction

    task automatic do_reset();
        resetn_i = 1'b0;
        mode = 0;
        exp_q.delete();
        expl_q.delete();
        exp_err_pend = 0;
        exp_vld_pend = 0;
        prev_hold = 0;
        #1;
        chk(m_axis_tdata == 0, "rst_tdata", m_axis_tdata, 0);
        chk(m_axis_tvalid == 0, "rst_tvalid", {31'b0, m_axis_tvalid}, 0);
        chk(m_axis_tlast == 0, "rst_tlast", {31'b0, m_axis_tlast}, 0);
        chk(busy_o == 0, "rst_busy", {31'b0, busy_o}, 0);
        chk(err_o == 0, "rst_err", {31'b0, err_o}, 0);
        repeat (3) @(posedge clk_i);
        #1 resetn_i = 1'b1;
    endtask

    task automatic send_px(input logic [7:0] p, input bit last);
        int n = 0;
        s_axis_tdata  = p;
        s_axis_tlast  = last;
        s_axis_tvalid = 1'b1;
        @(negedge clk_i);
        while (!s_axis_tready && n < 1000) begin
            @(negedge clk_i);
            n++;
        end
        if (n >= 1000) chk(0, "s_tready_timeout", 0, 1);
        @(posedge clk_i);
        #1;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    // pixmode 0: ramp 1..; 1: constant 200; 2: random. tl_at < 0 means tlast on the final pixel.
    task automatic send_frame(input int n, input logic [79:0] kern, input int pixmode, input int tl_at, input bit gaps);
        int cnt;
        logic [7:0] p;
        cnt = (tl_at >= 0) ? tl_at + 1 : n*n;
        kernel_i = kern;
        image_dimension_i = 5'(n);
        for (int i = 0; i < cnt; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) @(posedge clk_i);
                #1;
            end
            p = (pixmode == 0) ? 8'(i + 1) : (pixmode == 1) ? 8'd200 : 8'($urandom_range(0, 255));
            send_px(p, (i == cnt - 1));
            if (i == 0) begin
                kernel_i = 80'({$urandom, $urandom, $urandom});
                image_dimension_i = 5'($urandom);
            end
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || m_axis_tvalid) && n < 2000) begin
            @(negedge clk_i);
            n++;
        end
        if (n >= 2000) chk(0, "drain_timeout", exp_q.size(), 0);
        repeat (2) @(negedge clk_i);
        @(posedge clk_i);
        #1;
    endtask

    task automatic expect_got(input string name, input int n, input int v0, input int v1,
                              input int v2, input int v3, input bit fin);
        int v [4];
        v = '{v0, v1, v2, v3};
        chk(got_q.size() == n, {name, "_count"}, got_q.size(), n);
        for (int i = 0; i < n && i < got_q.size(); i++) begin
            chk(got_q[i] == v[i], {name, "_val"}, got_q[i], v[i]);
            chk(gotl_q[i] == (fin && i == n - 1), {name, "_last"}, {31'b0, gotl_q[i]},
                {31'b0, (fin && i == n - 1)});
        end
        got_q.delete();
        gotl_q.delete();
    endtask

    initial begin
        int n, tl;
        #2;
        do_reset();

        send_frame(4, kmk(1, 1, 0), 0, -1, 0);
        drain();
        expect_got("ramp4", 4, 54, 63, 90, 99, 1);
        chk(err_seen == 0, "ramp4_err", err_seen, 0);

        send_frame(3, kmk(0, -1, 5), 1, -1, 0);
        drain();
        expect_got("n3_neg", 1, -195, 0, 0, 0, 1);

        rdy_rnd = 1;
        send_frame(4, kmk(1, 1, 0), 0, -1, 1);
        drain();
        expect_got("ramp4_bp", 4, 54, 63, 90, 99, 1);
        rdy_rnd = 0;

        err_seen = 0;
        send_frame(4, kmk(1, 1, 0), 0, 10, 0);
        drain();
        expect_got("early_tlast", 1, 54, 0, 0, 0, 0);
        chk(err_seen == 1, "early_tlast_err", err_seen, 1);
        send_frame(4, kmk(1, 1, 0), 0, -1, 0);
        drain();
        expect_got("after_abort", 4, 54, 63, 90, 99, 1);

        err_seen = 0;
        send_frame(2, kmk(1, 1, 0), 0, -1, 0);
        drain();
        expect_got("drop_n2", 0, 0, 0, 0, 0, 0);
        chk(busy_o == 0, "drop_busy", {31'b0, busy_o}, 0);
        chk(err_seen == 0, "drop_err", err_seen, 0);

        rdy_rnd = 1;
        for (int f = 0; f < 24; f++) begin
            n  = (f % 7 == 6) ? 2 : $urandom_range(3, 8);
            tl = ($urandom_range(0, 4) == 0) ? $urandom_range(0, n*n - 1) : -1;
            send_frame(n, 80'({$urandom, $urandom, $urandom}), 2, tl, 1'($urandom_range(0, 1)));
        end
        drain();
        rdy_rnd = 0;
        got_q.delete();
        gotl_q.delete();

        rdy_zero = 1;
        kernel_i = kmk(1, 1, 0);
        image_dimension_i = 5'd4;
        for (int i = 0; i < 11; i++) send_px(8'(i + 1), 1'b0);
        @(negedge clk_i);
        chk(m_axis_tvalid == 1 && m_axis_tdata == 54, "pending_before_reset", m_axis_tdata, 54);
        #2;
        do_reset();
        rdy_zero = 0;
        got_q.delete();
        gotl_q.delete();
        send_frame(4, kmk(1, 1, 0), 0, -1, 0);
        drain();
        expect_got("after_reset", 4, 54, 63, 90, 99, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/conv3x3_stream.md
# conv3x3_stream

Streaming 3x3 convolution engine placed directly downstream of the control module. It consumes the latched kernel word (9 signed weights plus a bias) and the image dimension from that module. It accepts a raster-order pixel stream from DMA over AXI-Stream and produces the valid-region convolution outputs, (N-2)x(N-2) per N x N frame, on an AXI-Stream master. Two column-indexed line buffers and a 3x3 window register give one output per accepted pixel once the window is full.

## Interface
- PIXEL_WIDTH, 8, unsigned pixel width
- KERNEL_ENTRIES, 10, kernel word entries: 9 weights + bias
- WEIGHT_RES, 8, bits per kernel entry, signed two's complement
- MAX_DIM, 32, line buffer depth; legal N is 3..MAX_DIM-1
- OUT_WIDTH, 32, output width, signed, sign-extended result
- clk_i  in  1  clock; all logic on posedge
- resetn_i  in  1  reset, asynchronous, active-low
- kernel_i  in  KERNEL_ENTRIES*WEIGHT_RES  entry i = bits [WEIGHT_RES*i +: WEIGHT_RES]; entries 0..8 weights row-major (0 = top-left, 4 = centre); entry 9 = bias
- image_dimension_i  in  $clog2(MAX_DIM)  frame side N
- s_axis_tdata  in  PIXEL_WIDTH  pixel
- s_axis_tvalid  in  1  pixel valid
- s_axis_tlast  in  1  last pixel of frame
- s_axis_tready  out  1  pixel accepted when tvalid & tready
- m_axis_tdata  out  OUT_WIDTH  convolution result
- m_axis_tvalid  out  1  result valid
- m_axis_tready  in  1  downstream ready
- m_axis_tlast  out  1  last result of frame
- busy_o  out  1  state != IDLE
- err_o  out  1  one-cycle pulse on tlast/count mismatch

## Operation
- States: IDLE, RUN, DROP.
- IDLE: the first accepted pixel latches kernel_i and image_dimension_i into internal registers. If N>=3, go to RUN and process that pixel as (row 0, col 0). If N<3, go to DROP. kernel_i and image_dimension_i changes at any other time are ignored.
- RUN, per accepted pixel p at (r,c):
  - Window shifts one column left. The new right column is {lb1[c], lb0[c], p}, top to bottom.
  - Line buffer update: lb1[c]<=lb0[c], lb0[c]<=p.
  - c wraps at N-1 to 0 and r increments.
- Output condition: an output is produced when r>=2 and c>=2.
- Result: sum over k of w_k * window_k + bias.
  - Weights are signed; pixels are zero-extended.
  - Each product is 17-bit signed. The full-precision sum is 21 bits, sign-extended to OUT_WIDTH with no saturation.
- m_axis_tlast = 1 when the output's pixel is (N-1, N-1).
- Frame end is pixel (N-1, N-1) accepted: return to IDLE and clear r and c.
  - If s_axis_tlast=0 on that pixel, pulse err_o.
- Early tlast: s_axis_tlast=1 on any earlier pixel in RUN means pulse err_o, abort the frame, and return to IDLE with r and c cleared. Any output for that pixel is still produced. No further outputs for the frame.
- DROP: s_axis_tready=1. Pixels are discarded and no outputs are produced. Return to IDLE on the accepted tlast.
- Line buffers are not reset. Stale contents never reach an output, because r>=2 guarantees both rows were written in the current frame.

## Timing
- Reset (async assert, sync release): state IDLE, r=c=0, m_axis_tdata=0, m_axis_tvalid=0, m_axis_tlast=0, busy_o=0, err_o=0. Latched kernel and N are 0.
- Output stage is a single register. s_axis_tready = !m_axis_tvalid | m_axis_tready in IDLE and RUN; s_axis_tready = 1 in DROP.
- Latency: a pixel accepted in cycle t that meets the output condition gives m_axis_tvalid=1 with data in cycle t+1.
- m_axis_tvalid, m_axis_tdata and m_axis_tlast hold stable until m_axis_tready=1. Accept-out and accept-in in the same cycle reload the register, giving full throughput with no bubble.
- m_axis_tvalid falls the cycle after the handshake if no new result is loaded.
- err_o is high for exactly the cycle after the offending pixel is accepted.
- A new frame may start on the cycle immediately after the frame-end pixel is accepted. It latches fresh kernel and N while the previous last output may still be pending in the output register.
- Reset mid-frame clears all state immediately. Partial outputs are lost, and the next frame after release must be correct.

## Test plan
- 4x4 frame, pixels 1..16, all weights 1, bias 0 -> outputs 54, 63, 90, 99 in that order. tlast only on 99. No err_o.
- N=3, all pixels 200, weight 4 = 0xFF, all others 0, bias 5 -> single output 0xFFFFFF3D (-195) with tlast=1.
- Repeat the first scenario with m_axis_tready randomly toggled -> identical output sequence with no loss or duplication. s_axis_tready=0 whenever an output is held unaccepted.
- 4x4 frame with s_axis_tlast on pixel 10 -> err_o pulse, no outputs after pixel 10's result. Then a full 4x4 frame -> 54, 63, 90, 99.
- image_dimension_i=2, 4 pixels with tlast on the 4th -> all accepted, no m_axis_tvalid, busy_o low after tlast. kernel_i changed mid-frame in the first scenario -> results unchanged.
- Assert resetn_i mid-frame with an output pending -> all outputs 0 in the same cycle. After release, the first scenario produces 54, 63, 90, 99.
